// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter: round-robin address-phase grant with a hold limit,
// plus data-phase owner tracking for write-data and response steering.
module ahb_lite_arbiter_2m #(
  parameter int unsigned MAX_HOLD       = 4,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32
) (
  input  logic          clk,
  input  logic          reset,
  // master 0
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_write,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_aack,
  output logic          m0_ready,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  // master 1
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_write,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_aack,
  output logic          m1_ready,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  // shared slave-side bus
  output logic [AW-1:0] HADDR,
  output logic          HWRITE,
  output logic [1:0]    HTRANS,
  output logic [2:0]    HSIZE,
  output logic [DW-1:0] HWDATA,
  input  logic [DW-1:0] HRDATA,
  input  logic          HREADY,
  input  logic          HRESP
);

  localparam int unsigned    HCW         = $clog2(MAX_HOLD) + 1;
  localparam logic [HCW-1:0] HOLD_LAST   = HCW'(MAX_HOLD - 1);
  localparam logic           DEF_GNT     = 1'(DEFAULT_MASTER);
  localparam logic [1:0]     HTRANS_IDLE = 2'b00;
  localparam logic [1:0]     HTRANS_NSEQ = 2'b10;
  localparam logic [2:0]     HSIZE_WORD  = 3'b010;

  logic           gnt_q, gnt_d;
  logic           dvalid_q, dvalid_d;
  logic           downer_q, downer_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

  logic g_req;
  logic o_req;
  logic data_done;

  assign g_req = gnt_q ? m1_req : m0_req;
  assign o_req = gnt_q ? m0_req : m1_req;

  // Next-state: everything is frozen while the slave stalls.
  always_comb begin
    gnt_d      = gnt_q;
    dvalid_d   = dvalid_q;
    downer_d   = downer_q;
    hold_cnt_d = hold_cnt_q;
    if (HREADY) begin
      dvalid_d = g_req;
      downer_d = gnt_q;
      if (o_req && (!g_req || (hold_cnt_q == HOLD_LAST))) begin
        gnt_d      = ~gnt_q;
        hold_cnt_d = '0;
      end else if (g_req) begin
        // saturate so a lone master never wraps back into a fresh budget
        if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end else begin
        gnt_d      = DEF_GNT;
        hold_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q      <= DEF_GNT;
      dvalid_q   <= 1'b0;
      downer_q   <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      gnt_q      <= gnt_d;
      dvalid_q   <= dvalid_d;
      downer_q   <= downer_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Address phase follows the grant; data phase follows the recorded owner.
  assign HADDR  = gnt_q ? m1_addr : m0_addr;
  assign HWRITE = gnt_q ? m1_write : m0_write;
  assign HTRANS = (g_req && !reset) ? HTRANS_NSEQ : HTRANS_IDLE;
  assign HSIZE  = HSIZE_WORD;
  assign HWDATA = downer_q ? m1_wdata : m0_wdata;

  assign m0_aack = !reset && !gnt_q && m0_req && HREADY;
  assign m1_aack = !reset &&  gnt_q && m1_req && HREADY;

  assign data_done = !reset && dvalid_q && HREADY;
  assign m0_ready  = data_done && !downer_q;
  assign m1_ready  = data_done &&  downer_q;
  assign m0_err    = m0_ready && HRESP;
  assign m1_err    = m1_ready && HRESP;
  assign m0_rdata  = HRDATA;
  assign m1_rdata  = HRDATA;

endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// Bench for ahb_lite_arbiter_2m: directed vector table, contention/saturation
// sequences, then randomized traffic against a transaction-level model.
module tb_ahb_lite_arbiter_2m;

  localparam int MAX_HOLD = 4;
  localparam int DEF_M    = 0;

  logic        clk;
  logic        reset;
  logic        m_req   [2];
  logic [31:0] m_addr  [2];
  logic        m_write [2];
  logic [31:0] m_wdata [2];
  logic        m_aack  [2];
  logic        m_ready [2];
  logic        m_err   [2];
  logic [31:0] m_rdata [2];
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hready, hresp;
  logic [1:0]  htrans;
  logic [2:0]  hsize;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  ahb_lite_arbiter_2m #(.MAX_HOLD(MAX_HOLD), .DEFAULT_MASTER(DEF_M), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m_req[0]), .m0_addr(m_addr[0]), .m0_write(m_write[0]), .m0_wdata(m_wdata[0]),
    .m0_aack(m_aack[0]), .m0_ready(m_ready[0]), .m0_err(m_err[0]), .m0_rdata(m_rdata[0]),
    .m1_req(m_req[1]), .m1_addr(m_addr[1]), .m1_write(m_write[1]), .m1_wdata(m_wdata[1]),
    .m1_aack(m_aack[1]), .m1_ready(m_ready[1]), .m1_err(m_err[1]), .m1_rdata(m_rdata[1]),
    .HADDR(haddr), .HWRITE(hwrite), .HTRANS(htrans), .HSIZE(hsize), .HWDATA(hwdata),
    .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: actual %h required %h", nm, cyc, act, exp);
    end
  endtask

  // Transaction-level model: who holds the grant, how many beats in a row it has
  // had, and which master (if any) has a data phase outstanding.
  int mg, mhold, mdown;
  bit mdv;
  bit check_model = 0;
  bit last_aack [2];

  task automatic model_step();
    if (reset) begin
      mg = DEF_M; mhold = 0; mdv = 0; mdown = 0;
    end else if (hready) begin
      mdv   = m_req[mg];
      mdown = mg;
      if (m_req[1-mg] && (!m_req[mg] || mhold >= MAX_HOLD-1)) begin
        mg = 1 - mg; mhold = 0;
      end else if (m_req[mg]) begin
        if (mhold < MAX_HOLD-1) mhold++;
      end else begin
        mg = DEF_M; mhold = 0;
      end
    end
  endtask

  task automatic model_compare();
    bit live;
    live = !reset;
    chk("htrans", 32'(htrans), (live && m_req[mg]) ? 32'd2 : 32'd0);
    chk("hsize", 32'(hsize), 32'd2);
    if (live) begin
      chk("haddr", haddr, m_addr[mg]);
      chk("hwrite", 32'(hwrite), 32'(m_write[mg]));
      if (mdv) chk("hwdata", hwdata, m_wdata[mdown]);
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("aack%0d", i), 32'(m_aack[i]), 32'(live && mg == i && m_req[i] && hready));
      chk($sformatf("ready%0d", i), 32'(m_ready[i]), 32'(live && mdv && mdown == i && hready));
      chk($sformatf("err%0d", i), 32'(m_err[i]), 32'(live && mdv && mdown == i && hready && hresp));
      chk($sformatf("rdata%0d", i), m_rdata[i], hrdata);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    last_aack[0] = m_aack[0];
    last_aack[1] = m_aack[1];
    if (check_model) model_compare();
  endtask

  task automatic to_pos();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        r0, r1, w0;
    logic [31:0] a0, a1, d0;
    logic        hrdy, hrsp;
    logic [31:0] hrd;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic [1:0]  e_aack, e_ready, e_err;   // {m1, m0}
    logic        c_addr, c_wd, c_rd;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic r0, logic r1, logic w0, logic [31:0] a0,
                              logic [31:0] a1, logic [31:0] d0, logic hrdy, logic hrsp,
                              logic [31:0] hrd, logic [1:0] et, logic [31:0] ea,
                              logic [1:0] eak, logic [1:0] erd, logic [1:0] eer,
                              logic ca, logic cw, logic [31:0] ewd, logic cr);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.a0 = a0; v.a1 = a1; v.d0 = d0;
    v.hrdy = hrdy; v.hrsp = hrsp; v.hrd = hrd; v.e_trans = et; v.e_addr = ea;
    v.e_aack = eak; v.e_ready = erd; v.e_err = eer; v.c_addr = ca; v.c_wd = cw;
    v.e_wd = ewd; v.c_rd = cr;
    return v;
  endfunction

  initial begin
    vec_t v;
    int own, pown;
    reset = 1'b1; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 0; m_addr[i] = '0; m_write[i] = 0; m_wdata[i] = '0;
    end
    mg = DEF_M; mhold = 0; mdv = 0; mdown = 0;

    // reset with idle masters
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,0,0, 0,0,0, 1,0,0, 2'b00,0, 2'b00,2'b00,2'b00, 0,0,0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,0,0, 0,0,0, 1,0,0, 2'b00,0, 2'b00,2'b00,2'b00, 1,0,0,0));
    // master 0 single write
    tbl.push_back(mk(0,1,0,1, 88,0,32'h2ffffffe, 1,0,0, 2'b10,88, 2'b01,2'b00,2'b00, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1, 88,0,32'h2ffffffe, 1,0,0, 2'b00,88, 2'b00,2'b01,2'b00, 1,1,32'h2ffffffe,0));
    // master 1 read with two wait states (grant handover costs one cycle)
    tbl.push_back(mk(0,0,1,0, 88,96,0, 1,0,0, 2'b00,88, 2'b00,2'b00,2'b00, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 88,96,0, 1,0,0, 2'b10,96, 2'b10,2'b00,2'b00, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 88,96,0, 0,0,0, 2'b00,96, 2'b00,2'b00,2'b00, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 88,96,0, 0,0,0, 2'b00,96, 2'b00,2'b00,2'b00, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 88,96,0, 1,0,32'hcafe0060, 2'b00,96, 2'b00,2'b10,2'b00, 1,0,0,1));
    // error response on a master 0 read
    tbl.push_back(mk(0,1,0,0, 100,96,0, 1,0,0, 2'b10,100, 2'b01,2'b00,2'b00, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 100,96,0, 1,1,0, 2'b00,100, 2'b00,2'b01,2'b01, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 100,96,0, 1,0,0, 2'b00,100, 2'b00,2'b00,2'b00, 1,0,0,0));
    // reset while a master 1 data phase is stalled
    tbl.push_back(mk(0,0,1,0, 100,200,0, 1,0,0, 2'b00,100, 2'b00,2'b00,2'b00, 1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 100,200,0, 1,0,0, 2'b10,200, 2'b10,2'b00,2'b00, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 100,200,0, 0,0,0, 2'b00,200, 2'b00,2'b00,2'b00, 1,0,0,0));
    tbl.push_back(mk(1,0,0,0, 100,200,0, 0,0,0, 2'b00,0,   2'b00,2'b00,2'b00, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 300,200,0, 1,0,0, 2'b00,300, 2'b00,2'b00,2'b00, 1,0,0,0));

    foreach (tbl[k]) begin
      v = tbl[k];
      reset = v.rst; m_req[0] = v.r0; m_req[1] = v.r1; m_write[0] = v.w0; m_write[1] = 0;
      m_addr[0] = v.a0; m_addr[1] = v.a1; m_wdata[0] = v.d0; m_wdata[1] = 32'h5555_aaaa;
      hready = v.hrdy; hresp = v.hrsp; hrdata = v.hrd;
      to_neg();
      chk($sformatf("v%0d.htrans", k), 32'(htrans), 32'(v.e_trans));
      if (v.c_addr) chk($sformatf("v%0d.haddr", k), haddr, v.e_addr);
      chk($sformatf("v%0d.aack", k), 32'({m_aack[1], m_aack[0]}), 32'(v.e_aack));
      chk($sformatf("v%0d.ready", k), 32'({m_ready[1], m_ready[0]}), 32'(v.e_ready));
      chk($sformatf("v%0d.err", k), 32'({m_err[1], m_err[0]}), 32'(v.e_err));
      if (v.c_wd) chk($sformatf("v%0d.hwdata", k), hwdata, v.e_wd);
      if (v.c_rd) chk($sformatf("v%0d.rdata1", k), m_rdata[1], v.hrd);
      to_pos();
    end

    // continuous contention: four beats each, ready follows one cycle later
    check_model = 1;
    hready = 1; hresp = 0;
    pown = -1;
    for (int k = 0; k < 18; k++) begin
      own = (k / MAX_HOLD) % 2;
      for (int i = 0; i < 2; i++) begin
        m_req[i] = 1; m_addr[i] = 32'(i * 32'h1000 + k * 4); m_write[i] = 1; m_wdata[i] = $urandom;
      end
      to_neg();
      chk("cont.aack", 32'({m_aack[1], m_aack[0]}), (own == 1) ? 32'd2 : 32'd1);
      chk("cont.haddr", haddr, 32'(own * 32'h1000 + k * 4));
      chk("cont.ready", 32'({m_ready[1], m_ready[0]}),
          (pown < 0) ? 32'd0 : ((pown == 1) ? 32'd2 : 32'd1));
      to_pos();
      pown = own;
    end
    m_req[0] = 0; m_req[1] = 0;
    for (int k = 0; k < 2; k++) begin to_neg(); to_pos(); end

    // a lone master saturates its count, so a late contender wins right after one more beat
    m_req[0] = 1;
    for (int k = 0; k < 6; k++) begin to_neg(); to_pos(); end
    m_req[1] = 1;
    to_neg(); chk("sat.aack_m0", 32'({m_aack[1], m_aack[0]}), 32'd1); to_pos();
    to_neg(); chk("sat.aack_m1", 32'({m_aack[1], m_aack[0]}), 32'd2); to_pos();
    m_req[0] = 0; m_req[1] = 0;
    to_neg(); to_pos();

    // randomized traffic; masters hold req until their aack
    for (int k = 0; k < 3000; k++) begin
      reset  = ($urandom_range(199) == 0);
      hready = ($urandom_range(3) != 0);
      hresp  = ($urandom_range(9) == 0);
      hrdata = $urandom;
      for (int i = 0; i < 2; i++) begin
        if (!m_req[i] || last_aack[i]) begin
          if ($urandom_range(99) < 55) begin
            m_req[i] = 1; m_addr[i] = $urandom & 32'hffff_fffc; m_write[i] = 1'($urandom_range(1));
          end else begin
            m_req[i] = 0;
          end
        end
        m_wdata[i] = $urandom;
      end
      to_neg();
      to_pos();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
